// File: rtl/dram_req_issuer.sv
// dram_req_issuer
// Pops burst descriptors {len, addr} from a first-word-fall-through request
// FIFO and issues them to the DRAM controller as len+1 single-beat commands
// with addresses stepping by ADDR_STEP bytes.
//
// Handshake: a command beat transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. Once cmd_valid rises it stays high, with cmd_addr and
// cmd_last stable, until that transfer happens. cmd_ready is ignored while
// cmd_valid is 0. On the FIFO side, fifo_read_data is valid whenever
// fifo_empty is 0, and every cycle with fifo_read_en high pops one entry.
module dram_req_issuer #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 4,
    parameter int ADDR_STEP = 64,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    output logic                    fifo_read_en,
    input  logic [LEN_W+ADDR_W-1:0] fifo_read_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [ADDR_W-1:0]       cmd_addr,
    output logic                    cmd_last,
    output logic                    busy,
    output logic [CNT_W-1:0]        done_cnt
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    // IDLE: no burst held. ISSUE: a burst is held and cmd_valid is high.
    // busy mirrors the state directly, so it doubles as the state debug view.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic [CNT_W-1:0]   done_q;

    logic               accept;
    logic               last_beat;
    logic               pop;

    // Handshake decode and the pop decision. The pop can coincide with the
    // last-beat accept, which is what keeps back-to-back bursts gap-free.
    always_comb begin
        accept    = 1'b0;
        last_beat = 1'b0;
        pop       = 1'b0;
        if (state_q == ISSUE) begin
            accept    = cmd_ready;
            last_beat = (beat_q == len_q);
        end
        pop = !fifo_empty && ((state_q == IDLE) || (accept && last_beat));
    end

    // Next-state logic: a pop always lands in ISSUE; finishing a burst with
    // nothing to pop returns to IDLE; a stalled beat holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (accept && last_beat) begin
                    state_d = pop ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any burst in flight without replaying it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst datapath: load on pop, step address and beat count on a non-final
    // accept, count finished bursts on the final accept. Stalls hold all of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            done_q <= '0;
        end else begin
            if (pop) begin
                addr_q <= fifo_read_data[ADDR_W-1:0];
                len_q  <= fifo_read_data[LEN_W+ADDR_W-1:ADDR_W];
                beat_q <= '0;
            end else if (accept && !last_beat) begin
                addr_q <= addr_q + STEP;
                beat_q <= beat_q + 1'b1;
            end
            if (accept && last_beat) begin
                done_q <= done_q + 1'b1;
            end
        end
    end

    // Output drive; the pop strobe is forced low while reset is held so no
    // entry is consumed before the block is running.
    always_comb begin
        fifo_read_en = reset && pop;
        cmd_valid    = (state_q == ISSUE);
        cmd_addr     = addr_q;
        cmd_last     = last_beat;
        busy         = (state_q == ISSUE);
        done_cnt     = done_q;
    end

endmodule

// File: tb/tb_dram_req_issuer.sv
// Directed bench for dram_req_issuer: a queue-backed FIFO model feeds
// descriptors, a scoreboard holds the expected {last, addr} beat stream.
module tb_dram_req_issuer;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 16;

    logic                    clk;
    logic                    reset;
    logic                    fifo_empty;
    logic                    fifo_read_en;
    logic [LEN_W+ADDR_W-1:0] fifo_read_data;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_W-1:0]       cmd_addr;
    logic                    cmd_last;
    logic                    busy;
    logic [CNT_W-1:0]        done_cnt;

    dram_req_issuer #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .ADDR_STEP(64),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .fifo_read_data(fifo_read_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_last      (cmd_last),
        .busy          (busy),
        .done_cnt      (done_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    logic [LEN_W+ADDR_W-1:0] fifo_q[$];
    logic [ADDR_W:0]         exp_q[$];
    bit                      rdy_pat[$];
    int                      acc_cyc_q[$];
    int                      pop_cyc_q[$];
    int                      cyc;
    int                      n_total;
    int                      n_bad;
    bit                      stall_prev;
    logic [ADDR_W-1:0]       stall_addr;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_fifo();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_entry(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
        fifo_q.push_back({len, addr});
        drive_fifo();
    endtask

    task automatic expect_beat(input logic last, input logic [ADDR_W-1:0] addr);
        exp_q.push_back({last, addr});
    endtask

    // One clock: sample outputs at the falling edge, apply FIFO pops after the
    // rising edge, then set cmd_ready from the pattern (default 1).
    task automatic cycle();
        logic            pop_s;
        logic [ADDR_W:0] e;
        @(negedge clk);
        pop_s = fifo_read_en;
        if (fifo_empty) check("pop_while_empty", fifo_read_en, 0);
        if (stall_prev) begin
            check("stall_addr", cmd_addr, stall_addr);
            check("stall_valid", cmd_valid, 1);
        end
        if (pop_s) pop_cyc_q.push_back(cyc);
        if (cmd_valid && cmd_ready) begin
            acc_cyc_q.push_back(cyc);
            check("beat_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_addr", cmd_addr, e[ADDR_W-1:0]);
                check("beat_last", cmd_last, e[ADDR_W]);
            end
        end
        stall_prev = cmd_valid && !cmd_ready;
        stall_addr = cmd_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_s && fifo_q.size() != 0) fifo_q.pop_front();
        drive_fifo();
        if (cmd_valid && rdy_pat.size() != 0) cmd_ready = rdy_pat.pop_front();
        else cmd_ready = 1'b1;
    endtask

    // Run until the FIFO, scoreboard and block are all empty, with a bound.
    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy) break;
            cycle();
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    task automatic clear_hist();
        acc_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    // ---------------- directed tests ----------------
    int c0;

    initial begin
        n_total    = 0;
        n_bad      = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        stall_addr = '0;
        reset      = 1'b0;
        cmd_ready  = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;

        // T1: reset state with a pending entry, then a single-beat burst.
        push_entry(4'd0, 32'h0000_1000);
        @(negedge clk);
        check("rst_pop", fifo_read_en, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", cmd_addr, 0);
        check("rst_last", cmd_last, 0);
        check("rst_done", done_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_hist();
        expect_beat(1'b1, 32'h0000_1000);
        c0 = cyc;
        cycle();
        check("t1_pop_count", pop_cyc_q.size(), 1);
        check("t1_pop_cycle", (pop_cyc_q.size() != 0) ? pop_cyc_q[0] : -1, c0);
        check("t1_valid_next", cmd_valid, 1);
        check("t1_busy", busy, 1);
        drain(20);
        check("t1_done", done_cnt, 1);
        check("t1_pops", pop_cyc_q.size(), 1);

        // T2: four-beat burst at full throughput.
        clear_hist();
        push_entry(4'd3, 32'h0000_2000);
        expect_beat(1'b0, 32'h0000_2000);
        expect_beat(1'b0, 32'h0000_2040);
        expect_beat(1'b0, 32'h0000_2080);
        expect_beat(1'b1, 32'h0000_20C0);
        drain(30);
        check("t2_beats", acc_cyc_q.size(), 4);
        if (acc_cyc_q.size() == 4) check("t2_span", acc_cyc_q[3] - acc_cyc_q[0], 3);
        check("t2_done", done_cnt, 2);

        // T3: two queued entries issue without a bubble.
        clear_hist();
        push_entry(4'd1, 32'h0000_0000);
        push_entry(4'd0, 32'h0000_0400);
        expect_beat(1'b0, 32'h0000_0000);
        expect_beat(1'b1, 32'h0000_0040);
        expect_beat(1'b1, 32'h0000_0400);
        drain(30);
        check("t3_beats", acc_cyc_q.size(), 3);
        check("t3_pops", pop_cyc_q.size(), 2);
        if (acc_cyc_q.size() == 3) check("t3_span", acc_cyc_q[2] - acc_cyc_q[0], 2);
        if (acc_cyc_q.size() == 3 && pop_cyc_q.size() == 2)
            check("t3_pop_on_last", pop_cyc_q[1], acc_cyc_q[1]);
        check("t3_done", done_cnt, 4);

        // T4: back-pressure pattern 1,0,0,1,0,1.
        clear_hist();
        rdy_pat = '{1, 0, 0, 1, 0, 1};
        push_entry(4'd2, 32'h0000_3000);
        expect_beat(1'b0, 32'h0000_3000);
        expect_beat(1'b0, 32'h0000_3040);
        expect_beat(1'b1, 32'h0000_3080);
        drain(30);
        check("t4_beats", acc_cyc_q.size(), 3);
        if (acc_cyc_q.size() == 3) check("t4_span", acc_cyc_q[2] - acc_cyc_q[0], 5);
        check("t4_done", done_cnt, 5);

        // T5: address wraps past the top of the address space.
        clear_hist();
        push_entry(4'd1, 32'hFFFF_FFC0);
        expect_beat(1'b0, 32'hFFFF_FFC0);
        expect_beat(1'b1, 32'h0000_0000);
        drain(20);
        check("t5_beats", acc_cyc_q.size(), 2);
        check("t5_done", done_cnt, 6);

        // T6: asynchronous reset during the second beat of a four-beat burst.
        clear_hist();
        push_entry(4'd3, 32'h0000_5000);
        push_entry(4'd0, 32'h0000_6000);
        expect_beat(1'b0, 32'h0000_5000);
        for (int i = 0; i < 20 && acc_cyc_q.size() < 1; i++) cycle();
        check("t6_first_beat", acc_cyc_q.size(), 1);
        check("t6_second_addr", cmd_addr, 32'h0000_5040);
        check("t6_pre_valid", cmd_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", cmd_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done_cnt, 0);
        check("t6_rst_last", cmd_last, 0);
        check("t6_rst_pop", fifo_read_en, 0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cmd_ready = 1'b1;
        clear_hist();
        expect_beat(1'b1, 32'h0000_6000);
        drain(20);
        check("t6_beats", acc_cyc_q.size(), 1);
        check("t6_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_req_issuer.md
Name: dram_req_issuer

Overview:
- Consumer for the read side of the request FIFO.
- Pops one burst descriptor per FIFO entry and splits it into single-beat DRAM commands with incrementing addresses.
- Drives the DRAM command port with a valid/ready handshake.
- Sits between the cache-miss request FIFO and the DRAM controller command input.

Parameters:
- ADDR_W, 32, command address width in bits.
- LEN_W, 4, width of the beat-count field; a burst is len+1 beats, 1..2^LEN_W.
- ADDR_STEP, 64, byte increment between consecutive beats.
- CNT_W, 16, width of the completed-burst counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_en  output  1  FIFO pop strobe; one pop per cycle it is high.
- fifo_read_data  input  LEN_W+ADDR_W  FIFO head entry {len, addr}; first-word-fall-through, valid whenever fifo_empty=0.
- cmd_valid  output  1  command beat valid.
- cmd_ready  input  1  downstream accepts the beat.
- cmd_addr  output  ADDR_W  beat address.
- cmd_last  output  1  final beat of the current burst.
- busy  output  1  high while a burst is held (state ISSUE).
- done_cnt  output  CNT_W  number of bursts fully issued.

Behaviour:
- Reset (reset=0, async): state=IDLE, cmd_valid=0, cmd_addr=0, cmd_last=0, busy=0, done_cnt=0, beat counter=0, internal len=0.
  - fifo_read_en=0 while reset is asserted.
  - A burst in progress is dropped; its popped entry is lost, not replayed.
- States:
  - IDLE: no burst held.
  - ISSUE: burst held; cmd_valid=1.
- Beat accept: a beat is accepted on a cycle with cmd_valid and cmd_ready both 1.
- Pop condition (combinational): fifo_read_en = !fifo_empty && (state==IDLE || (beat accepted && cmd_last)).
  - Never asserted when fifo_empty=1.
- On a pop cycle the block registers fifo_read_data in the same cycle: addr into cmd_addr, len into len_reg, beat counter cleared to 0. State goes to ISSUE.
- Latency: FIFO non-empty in IDLE -> cmd_valid=1 on the next cycle (1 cycle).
- Back-to-back bursts: the last-beat accept and the next pop happen in the same cycle, so there is no bubble; cmd_valid stays 1.
- ISSUE, beat accepted, not last:
  - cmd_addr <= cmd_addr + ADDR_STEP, truncated to ADDR_W (wraps modulo 2^ADDR_W, no error).
  - Beat counter increments.
- ISSUE, beat accepted, last:
  - done_cnt increments; wraps at 2^CNT_W.
  - Then pop the next entry if available, else go to IDLE with cmd_valid=0.
- cmd_last = (beat counter == len_reg) while in ISSUE; 0 otherwise. len=0 gives a single beat with cmd_last=1.
- Stall: while cmd_valid=1 and cmd_ready=0, cmd_addr, cmd_last and all internal state hold stable. cmd_valid never deasserts before acceptance.
- cmd_ready while cmd_valid=0: ignored.
- busy = (state==ISSUE).
- Beat counter width: LEN_W.

Test Plan:
- Reset, then one entry {len=0, addr=0x1000}: fifo_read_en pulses 1 cycle; next cycle cmd_valid=1, cmd_addr=0x1000, cmd_last=1. With cmd_ready=1 -> IDLE, done_cnt=1.
- Entry {len=3, addr=0x2000}, cmd_ready=1: beats at 0x2000, 0x2040, 0x2080, 0x20C0 on 4 consecutive cycles; cmd_last only on 0x20C0.
- Two queued entries {1, 0x0}, {0, 0x400}, cmd_ready=1: 3 consecutive valid beats 0x0, 0x40, 0x400 with no gap; the second fifo_read_en coincides with the 0x40 accept.
- Entry {2, 0x3000}, cmd_ready toggling 1,0,0,1,0,1: cmd_addr holds during stalls; 3 beats total; cmd_last only on 0x3080.
- Entry {1, 0xFFFFFFC0}: beats 0xFFFFFFC0, then 0x00000000.
- reset asserted mid-burst (second beat of a len=3 burst): cmd_valid, busy, done_cnt drop to 0 immediately and asynchronously; after release, the next FIFO entry is issued normally.
